// File: rtl/subservient_dbg_pkg.sv
// Shared opcode/response constants and FSM state type for the debug-bus host.
package subservient_dbg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_HALT  = 8'h48;
    localparam logic [7:0] OP_GO    = 8'h47;
    localparam logic [7:0] RSP_OK   = 8'h4b;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } dbg_state_t;

    // W and R carry a 4-byte address and go through the operand states
    function automatic logic is_bus_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/subservient_dbg_host.sv
// Byte-stream command decoder that issues single-word Wishbone accesses on the
// core's debug port and controls the core's debug-mode input.
module subservient_dbg_host
    import subservient_dbg_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter bit DEBUG_RESET = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);

    dbg_state_t  state;
    dbg_state_t  state_next;
    logic [7:0]  opcode;
    logic [1:0]  byte_cnt;
    logic [1:0]  resp_idx;
    logic        resp_err;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic [TW-1:0] tmo_cnt;
    logic        debug_mode;

    logic rx_accepting;
    logic rx_fire;
    logic tx_fire;
    logic last_operand;
    logic resp_last;

    // Receive side is open only in the command-collecting states and never in reset
    assign rx_accepting = ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA)) && !i_rst;
    assign rx_fire      = i_rx_valid && rx_accepting;
    assign tx_fire      = (state == ST_RESP) && i_tx_ready;
    assign last_operand = rx_fire && (byte_cnt == 2'd3);
    assign resp_last    = ((opcode == OP_READ) && !resp_err) ? (resp_idx == 2'd3) : 1'b1;

    assign o_rx_ready   = rx_accepting;
    assign o_debug_mode = debug_mode;
    assign o_wb_dbg_adr = adr;
    assign o_wb_dbg_dat = dat;
    assign o_wb_dbg_sel = 4'hf;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus the state-derived bus and response outputs
    always_comb begin
        state_next   = state;
        o_wb_dbg_stb = 1'b0;
        o_wb_dbg_we  = 1'b0;
        o_tx_valid   = 1'b0;
        o_tx_data    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (rx_fire) state_next = is_bus_op(i_rx_data) ? ST_ADDR : ST_RESP;
            end
            ST_ADDR: begin
                if (last_operand) begin
                    if (opcode == OP_WRITE) state_next = ST_DATA;
                    else                    state_next = debug_mode ? ST_BUS : ST_RESP;
                end
            end
            ST_DATA: begin
                if (last_operand) state_next = debug_mode ? ST_BUS : ST_RESP;
            end
            ST_BUS: begin
                o_wb_dbg_stb = 1'b1;
                o_wb_dbg_we  = (opcode == OP_WRITE);
                if (i_wb_dbg_ack || (tmo_cnt == TW'(1))) state_next = ST_RESP;
            end
            ST_RESP: begin
                o_tx_valid = 1'b1;
                if (resp_err)                o_tx_data = RSP_ERR;
                else if (opcode == OP_READ)  o_tx_data = rdata[{resp_idx, 3'b000} +: 8];
                else                         o_tx_data = RSP_OK;
                if (tx_fire && resp_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command capture, operand assembly, bus timeout and response sequencing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            opcode     <= 8'h00;
            byte_cnt   <= 2'd0;
            resp_idx   <= 2'd0;
            resp_err   <= 1'b0;
            adr        <= 32'h0;
            dat        <= 32'h0;
            rdata      <= 32'h0;
            tmo_cnt    <= '0;
            debug_mode <= DEBUG_RESET;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        opcode   <= i_rx_data;
                        byte_cnt <= 2'd0;
                        resp_idx <= 2'd0;
                        resp_err <= !(is_bus_op(i_rx_data) || (i_rx_data == OP_HALT) ||
                                      (i_rx_data == OP_GO));
                        if (i_rx_data == OP_HALT) debug_mode <= 1'b1;
                        if (i_rx_data == OP_GO)   debug_mode <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        adr      <= {i_rx_data, adr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    if (last_operand && (opcode == OP_READ)) begin
                        if (debug_mode) tmo_cnt  <= TW'(TIMEOUT);
                        else            resp_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        dat      <= {i_rx_data, dat[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    if (last_operand) begin
                        if (debug_mode) tmo_cnt  <= TW'(TIMEOUT);
                        else            resp_err <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (i_wb_dbg_ack) begin
                        rdata <= i_wb_dbg_rdt;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                        if (tmo_cnt == TW'(1)) resp_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (tx_fire) resp_idx <= resp_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subservient_dbg_host.sv
// Randomized self-checking bench for subservient_dbg_host against a command-level model.
module tb_subservient_dbg_host;
    import subservient_dbg_pkg::*;

    localparam int TO = 8;
    localparam bit DR = 1'b0;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_debug_mode;
    logic [31:0] o_wb_dbg_adr;
    logic [31:0] o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we;
    logic        o_wb_dbg_stb;
    logic [31:0] i_wb_dbg_rdt = 32'h0;
    logic        i_wb_dbg_ack = 1'b0;

    int check_count = 0;
    int pass_count  = 0;
    int stb_total   = 0;

    bit          mdl_debug;
    logic [31:0] mdl_mem [logic [31:0]];
    logic [7:0]  exp_resp [$];

    always #5 i_clk = ~i_clk;

    subservient_dbg_host #(.TIMEOUT(TO), .DEBUG_RESET(DR)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_debug_mode (o_debug_mode),
        .o_wb_dbg_adr (o_wb_dbg_adr),
        .o_wb_dbg_dat (o_wb_dbg_dat),
        .o_wb_dbg_sel (o_wb_dbg_sel),
        .o_wb_dbg_we  (o_wb_dbg_we),
        .o_wb_dbg_stb (o_wb_dbg_stb),
        .i_wb_dbg_rdt (i_wb_dbg_rdt),
        .i_wb_dbg_ack (i_wb_dbg_ack)
    );

    // Total number of cycles the strobe has been seen high
    always @(negedge i_clk) begin
        if (o_wb_dbg_stb === 1'b1) stb_total <= stb_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mdl_mem.exists(a)) return mdl_mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic sendByte(input logic [7:0] b);
        int n;
        i_rx_valid   = 1'b1;
        i_rx_data    = b;
        i_wb_dbg_ack = 1'($urandom_range(0, 1));
        n = 0;
        while (o_rx_ready !== 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n == 50) checkOutput("rx_ready_wait", 32'(o_rx_ready), 32'd1);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic receiveResponse(input int hold_len);
        int n;
        int hold;
        logic [7:0] first;
        bit stable;
        for (int i = 0; i < exp_resp.size(); i++) begin
            n = 0;
            while (o_tx_valid !== 1'b1 && n < 50) begin
                @(negedge i_clk);
                n++;
            end
            if (n == 50) begin
                checkOutput("tx_valid_wait", 32'(o_tx_valid), 32'd1);
                return;
            end
            hold   = (hold_len >= 0) ? hold_len : int'($urandom_range(0, 3));
            first  = o_tx_data;
            stable = 1'b1;
            i_tx_ready = 1'b0;
            i_rx_valid = 1'b1;
            i_rx_data  = OP_READ;
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clk);
                if (o_tx_data !== first || o_rx_ready !== 1'b0 || o_tx_valid !== 1'b1) stable = 1'b0;
            end
            i_rx_valid = 1'b0;
            if (hold > 0) checkOutput("tx_hold_stable", 32'(stable), 32'd1);
            checkOutput($sformatf("tx_byte%0d", i), 32'(o_tx_data), 32'(exp_resp[i]));
            i_tx_ready = 1'b1;
            @(negedge i_clk);
            i_tx_ready = 1'b0;
        end
        checkOutput("idle_rx_ready", 32'(o_rx_ready), 32'd1);
        checkOutput("idle_tx_valid", 32'(o_tx_valid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                                 input int waits, input bit noack, input int hold_len);
        int start_stb;
        int n;
        bit exp_bus;
        logic [31:0] rd;
        exp_resp.delete();
        exp_bus = 1'b0;
        if (op == OP_HALT) begin
            mdl_debug = 1'b1;
            exp_resp.push_back(RSP_OK);
        end else if (op == OP_GO) begin
            mdl_debug = 1'b0;
            exp_resp.push_back(RSP_OK);
        end else if (op == OP_WRITE || op == OP_READ) begin
            if (!mdl_debug) exp_resp.push_back(RSP_ERR);
            else begin
                exp_bus = 1'b1;
                if (noack) exp_resp.push_back(RSP_ERR);
                else if (op == OP_WRITE) begin
                    mdl_mem[adr] = dat;
                    exp_resp.push_back(RSP_OK);
                end else begin
                    rd = memRead(adr);
                    for (int k = 0; k < 4; k++) exp_resp.push_back(rd[8*k +: 8]);
                end
            end
        end else begin
            exp_resp.push_back(RSP_ERR);
        end

        start_stb = stb_total;
        sendByte(op);
        if (op == OP_WRITE || op == OP_READ) begin
            for (int k = 0; k < 4; k++) sendByte(adr[8*k +: 8]);
            if (op == OP_WRITE) for (int k = 0; k < 4; k++) sendByte(dat[8*k +: 8]);
        end
        i_wb_dbg_ack = 1'b0;
        checkOutput("stb_rise", 32'(o_wb_dbg_stb), 32'(exp_bus));
        checkOutput("debug_at_resp", 32'(o_debug_mode), 32'(mdl_debug));
        if (exp_bus) begin
            n = 0;
            while (o_wb_dbg_stb === 1'b1 && n < 300) begin
                n++;
                checkOutput("bus_adr", o_wb_dbg_adr, adr);
                checkOutput("bus_we", 32'(o_wb_dbg_we), 32'(op == OP_WRITE));
                checkOutput("bus_sel", 32'(o_wb_dbg_sel), 32'hf);
                if (op == OP_WRITE) checkOutput("bus_dat", o_wb_dbg_dat, dat);
                if (!noack && n == waits + 1) begin
                    i_wb_dbg_ack = 1'b1;
                    i_wb_dbg_rdt = (op == OP_READ) ? memRead(adr) : $urandom;
                end
                @(negedge i_clk);
                i_wb_dbg_ack = 1'b0;
            end
            checkOutput("tx_after_bus", 32'(o_tx_valid), 32'd1);
        end
        receiveResponse(hold_len);
        checkOutput("stb_cycles", 32'(stb_total - start_stb),
                    exp_bus ? (noack ? 32'(TO) : 32'(waits + 1)) : 32'd0);
        checkOutput("debug_mode", 32'(o_debug_mode), 32'(mdl_debug));
    endtask

    task automatic resetDuringBus();
        logic [31:0] a;
        a = 32'h200;
        sendByte(OP_READ);
        for (int k = 0; k < 4; k++) sendByte(a[8*k +: 8]);
        i_wb_dbg_ack = 1'b0;
        checkOutput("rst_stb_before", 32'(o_wb_dbg_stb), 32'd1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_stb", 32'(o_wb_dbg_stb), 32'd0);
        checkOutput("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("rst_debug", 32'(o_debug_mode), 32'(DR));
        checkOutput("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        checkOutput("rst_adr", o_wb_dbg_adr, 32'h0);
        i_rst = 1'b0;
        mdl_debug = DR;
        @(negedge i_clk);
        checkOutput("rst_rx_ready_after", 32'(o_rx_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] op;
        int sel;
        mdl_debug = DR;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_rx_ready", 32'(o_rx_ready), 32'd0);
        checkOutput("reset_tx_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("reset_stb", 32'(o_wb_dbg_stb), 32'd0);
        checkOutput("reset_we", 32'(o_wb_dbg_we), 32'd0);
        checkOutput("reset_adr", o_wb_dbg_adr, 32'h0);
        checkOutput("reset_dat", o_wb_dbg_dat, 32'h0);
        checkOutput("reset_sel", 32'(o_wb_dbg_sel), 32'hf);
        checkOutput("reset_tx_data", 32'(o_tx_data), 32'h0);
        checkOutput("reset_debug", 32'(o_debug_mode), 32'(DR));
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("first_idle_ready", 32'(o_rx_ready), 32'd1);

        applyStimulus(OP_READ,  32'h100, 32'h0,        0, 1'b0, -1);
        applyStimulus(OP_HALT,  32'h0,   32'h0,        0, 1'b0, -1);
        applyStimulus(OP_WRITE, 32'h100, 32'hdeadbeef, 0, 1'b0, -1);
        applyStimulus(OP_READ,  32'h100, 32'h0,        3, 1'b0, -1);
        applyStimulus(OP_READ,  32'h100, 32'h0,        0, 1'b1, -1);
        applyStimulus(OP_READ,  32'h100, 32'h0,        0, 1'b0, -1);
        applyStimulus(OP_GO,    32'h0,   32'h0,        0, 1'b0, -1);
        applyStimulus(OP_WRITE, 32'h100, 32'h12345678, 0, 1'b0, -1);
        applyStimulus(8'h58,    32'h0,   32'h0,        0, 1'b0, -1);
        applyStimulus(OP_HALT,  32'h0,   32'h0,        0, 1'b0, -1);
        applyStimulus(OP_READ,  32'h100, 32'h0,        1, 1'b0, 10);

        for (int t = 0; t < 60; t++) begin
            sel = int'($urandom_range(0, 11));
            if (sel < 4)       op = OP_WRITE;
            else if (sel < 7)  op = OP_READ;
            else if (sel < 9)  op = OP_HALT;
            else if (sel < 10) op = OP_GO;
            else begin
                op = 8'($urandom);
                while (is_bus_op(op) || op == OP_HALT || op == OP_GO) op = 8'($urandom);
            end
            applyStimulus(op, 32'h1000 + 32'(4 * $urandom_range(0, 7)), $urandom,
                          int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), -1);
        end

        applyStimulus(OP_HALT, 32'h0, 32'h0, 0, 1'b0, -1);
        resetDuringBus();
        applyStimulus(OP_READ, 32'h100, 32'h0, 0, 1'b0, -1);
        applyStimulus(OP_HALT, 32'h0,   32'h0, 0, 1'b0, -1);
        applyStimulus(OP_READ, 32'h100, 32'h0, 2, 1'b0, -1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/subservient_dbg_host.md
# subservient_dbg_host

Debug-bus initiator for the subservient SoC. Takes a byte-stream command protocol, typically fed by a UART receiver, and turns it into single-word Wishbone accesses on the core's debug port. It also drives the core's debug-mode input, so a host can halt the CPU, load or inspect SRAM, and release the CPU. It sits outside `subservient_core` and connects directly to `i_debug_mode` and the `i_wb_dbg_*`/`o_wb_dbg_*` ports.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles to wait for `i_wb_dbg_ack` before aborting. Minimum 1.
- `DEBUG_RESET`, default 1: reset value of `o_debug_mode`.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  command byte.
- `i_rx_valid`  in  1  command byte valid.
- `o_rx_ready`  out  1  command byte accepted when valid&ready.
- `o_tx_data`  out  8  response byte.
- `o_tx_valid`  out  1  response byte valid.
- `i_tx_ready`  in  1  response byte consumed when valid&ready.
- `o_debug_mode`  out  1  to core `i_debug_mode`.
- `o_wb_dbg_adr`  out  32  bus address.
- `o_wb_dbg_dat`  out  32  write data.
- `o_wb_dbg_sel`  out  4  byte select; always 4'hf.
- `o_wb_dbg_we`  out  1  write enable.
- `o_wb_dbg_stb`  out  1  strobe.
- `i_wb_dbg_rdt`  in  32  read data.
- `i_wb_dbg_ack`  in  1  acknowledge.

## Operation
Commands are ASCII opcodes. Multi-byte fields are little-endian (LSB first).
- `W` a0..a3 d0..d3: word write. Response `K`.
- `R` a0..a3: word read. Response r0..r3, LSB first.
- `H`: halt. Sets `o_debug_mode`=1. Response `K`.
- `G`: go. Clears `o_debug_mode`. Response `K`.
- Any other opcode: response `E`. The opcode is consumed and no further bytes are consumed for it.
- `W`/`R` while `o_debug_mode`=0: all operand bytes are consumed, no bus access is made, response `E`.
- Bus timeout: response `E`. For `R`, only `E` is sent; no data bytes follow.

FSM states:
- IDLE: `o_rx_ready`=1. Latches the opcode. Moves to ADDR for W/R, otherwise to RESP.
- ADDR: `o_rx_ready`=1. A 2-bit counter collects 4 bytes. Moves to DATA for W; for R, moves to BUS (or RESP with `E` if not in debug mode).
- DATA: `o_rx_ready`=1. Collects 4 bytes, then moves to BUS or RESP.
- BUS: `o_wb_dbg_stb`=1; adr/dat/we are stable for the whole state. A timeout counter loads `TIMEOUT` on entry and decrements each cycle without ack.
  - On ack: captures `i_wb_dbg_rdt` for R and moves to RESP.
  - If the counter reaches 0 without ack: moves to RESP with `E`.
- RESP: `o_tx_valid`=1. Response length is 1 byte, or 4 for a successful R. A byte index advances on each tx handshake; after the last byte the FSM returns to IDLE.
- `o_rx_ready`=0 in BUS and RESP; bytes are backpressured, not dropped.

## Timing
- Reset values: `o_rx_ready`=0 during reset, then 1 in IDLE on the first cycle after reset. `o_tx_valid`=0, `o_wb_dbg_stb`=0, `o_wb_dbg_we`=0, `o_wb_dbg_adr`=0, `o_wb_dbg_dat`=0, `o_wb_dbg_sel`=4'hf, `o_tx_data`=0, `o_debug_mode`=`DEBUG_RESET`.
- Accepting a byte takes one cycle per valid&ready, so back-to-back bytes are accepted at 1 per cycle.
- `o_wb_dbg_stb` rises the cycle after the last operand byte is accepted.
- Ack is sampled on the clock edge; `stb` is low the cycle after the ack cycle. Ack seen while `stb`=0 is ignored.
- Zero-wait-state responder: stb is high for exactly 1 cycle, and `o_tx_valid` is high the cycle after ack.
- Timeout: stb is held for exactly `TIMEOUT` cycles, then `E` is presented the next cycle.
- Ack arriving on the same cycle the counter hits 0: ack wins, and the access is reported as success.
- `o_tx_data` is stable while `o_tx_valid`=1 and `i_tx_ready`=0.
- `H`/`G`: `o_debug_mode` changes on the cycle the response enters RESP, before `K` is sent.
- `i_rst` mid-operation: everything aborts, including an in-flight bus cycle (stb low the next cycle), and all outputs return to their reset values.

## Structure
- Shared package `subservient_dbg_pkg` holds:
  - opcode and response constants (`W`=8'h57, `R`=8'h52, `H`=8'h48, `G`=8'h47, `K`=8'h4b, `E`=8'h45);
  - the FSM state enum.
- Single flat module. No sub-module, since the UART is external.

## Test plan
- After reset, send `H` -> `o_debug_mode`=1, tx `K`. Then send `W` 00 01 00 00 EF BE AD DE -> one write strobe, adr=32'h100, dat=32'hdeadbeef, we=1, tx `K`.
- Send `R` 00 01 00 00 with a responder returning 32'hdeadbeef after 3 wait states -> stb high for 4 cycles; tx EF, BE, AD, DE.
- Set `TIMEOUT`=8 with no ack -> stb high for exactly 8 cycles, tx `E`, FSM back in IDLE, and the next `R` works.
- Send `G`, then `W` plus 8 operand bytes -> no stb ever; all 8 operand bytes consumed; tx `E`.
- Send `X` (8'h58) -> tx `E`. Hold `i_tx_ready`=0 for 10 cycles during a read response -> `o_tx_data` stable and `o_rx_ready`=0 throughout.
- Assert `i_rst` while stb=1 -> stb=0 on the next cycle; `o_debug_mode`=`DEBUG_RESET`, `o_tx_valid`=0.
